// File: rtl/psum_pack_1_16.sv
// ---------------------------------------------------------------------------
// psum_pack_1_16
//
// Serial-to-parallel packer feeding the 16-to-1 FP16 adder tree. Partial sums
// arrive one word per beat on a ready/valid stream and are collected into one
// of two ping-pong banks. When a bank holds LANES words it is presented as one
// LANES*DATA_W vector on a second ready/valid interface, while the other bank
// keeps collecting. Lane words are opaque bit patterns; nothing is interpreted.
//
// Parameters
//   DATA_W  width of one lane (FP16 bit pattern)
//   LANES   lanes per output vector, power of two, >= 2
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   flush      (only with PSUM_PACK_FLUSH_EN) close a partial bank, zero-padded
//   in_valid   input word valid
//   in_ready   packer can take a word this cycle (registered state only)
//   in_data    input word
//   vec_valid  packed vector available
//   vec_ready  downstream accepts the vector
//   vec_data   packed vector, lane k at bits [k*DATA_W +: DATA_W]
//   lane_cnt   number of lanes filled in the current write bank
//
// Build option
//   PSUM_PACK_FLUSH_EN  adds the flush input. Without it a vector is emitted
//                       only after exactly LANES accepted words.
// ---------------------------------------------------------------------------
module psum_pack_1_16 #(
   parameter int DATA_W = 16,
   parameter int LANES  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
`ifdef PSUM_PACK_FLUSH_EN
   input  logic                      flush,
`endif
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_data,
   output logic                      vec_valid,
   input  logic                      vec_ready,
   output logic [LANES*DATA_W-1:0]   vec_data,
   output logic [$clog2(LANES):0]    lane_cnt
);

   localparam int PTR_W = $clog2(LANES);
   localparam int VEC_W = LANES * DATA_W;
   localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

   // Bank storage and control state
   logic [VEC_W-1:0] bank0_q;
   logic [VEC_W-1:0] bank1_q;
   logic [1:0]       full_q;
   logic [1:0]       full_d;
   logic             wr_sel_q;
   logic             wr_sel_d;
   logic             rd_sel_q;
   logic             rd_sel_d;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] wr_ptr_d;

   // Write-side datapath
   logic [VEC_W-1:0] wr_cur;
   logic [VEC_W-1:0] wr_vec_d;

   // Handshake / event decode
   logic in_acc;
   logic vec_acc;
   logic lane_last;
   logic flush_go;
   logic bank_done;
   logic bank_wr;

   // -----------------------------------------------------------------------
   // Handshake decode. in_ready and vec_valid come straight from registered
   // full flags, so neither ready nor valid has a combinational input path.
   // -----------------------------------------------------------------------
   assign in_ready  = ~full_q[wr_sel_q];
   assign vec_valid = full_q[rd_sel_q];
   assign vec_data  = rd_sel_q ? bank1_q : bank0_q;
   assign lane_cnt  = {1'b0, wr_ptr_q};

   assign in_acc    = in_valid & in_ready;
   assign vec_acc   = vec_valid & vec_ready;
   assign lane_last = (wr_ptr_q == LAST_LANE);

`ifdef PSUM_PACK_FLUSH_EN
   // A flush closes the bank only if it actually holds something: either
   // earlier words (wr_ptr > 0) or the word being accepted this very cycle.
   assign flush_go = flush & in_ready & (in_acc | (wr_ptr_q != '0));
`else
   assign flush_go = 1'b0;
`endif

   // Bank closes on the last lane or on an effective flush
   assign bank_done = (in_acc & lane_last) | flush_go;
   assign bank_wr   = in_acc | flush_go;

   // -----------------------------------------------------------------------
   // Next contents of the write bank: the accepted word lands in lane
   // wr_ptr; on a flush every lane from wr_ptr upward that did not just
   // receive the word is padded with zero (+0.0).
   // -----------------------------------------------------------------------
   assign wr_cur = wr_sel_q ? bank1_q : bank0_q;

   always_comb begin
      wr_vec_d = wr_cur;
      for (int k = 0; k < LANES; k++) begin
         if (in_acc && (wr_ptr_q == PTR_W'(k))) begin
            wr_vec_d[k*DATA_W +: DATA_W] = in_data;
         end else if (flush_go && (PTR_W'(k) >= wr_ptr_q)) begin
            wr_vec_d[k*DATA_W +: DATA_W] = '0;
         end
      end
   end

   // -----------------------------------------------------------------------
   // Control next-state. A bank completing and the other bank being read
   // out on the same edge touch different full bits (the write bank is
   // empty, the read bank is full), so both updates simply apply.
   // -----------------------------------------------------------------------
   always_comb begin
      full_d   = full_q;
      wr_sel_d = wr_sel_q;
      rd_sel_d = rd_sel_q;
      wr_ptr_d = wr_ptr_q;

      if (bank_done) begin
         full_d[wr_sel_q] = 1'b1;
         wr_sel_d         = ~wr_sel_q;
         wr_ptr_d         = '0;
      end else if (in_acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (vec_acc) begin
         full_d[rd_sel_q] = 1'b0;
         rd_sel_d         = ~rd_sel_q;
      end
   end

   // -----------------------------------------------------------------------
   // State registers. Reset clears the bank data too so vec_data reads zero
   // after reset and any partial fill is discarded.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank0_q  <= '0;
         bank1_q  <= '0;
         full_q   <= '0;
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
         wr_ptr_q <= '0;
      end else begin
         full_q   <= full_d;
         wr_sel_q <= wr_sel_d;
         rd_sel_q <= rd_sel_d;
         wr_ptr_q <= wr_ptr_d;
         if (bank_wr) begin
            if (wr_sel_q) begin
               bank1_q <= wr_vec_d;
            end else begin
               bank0_q <= wr_vec_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_psum_pack_1_16.sv
`timescale 1ns/1ps
module tb_psum_pack_1_16;

   localparam int DATA_W = 16;
   localparam int LANES  = 16;
   localparam int VEC_W  = DATA_W * LANES;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              vec_valid;
   logic              vec_ready = 1'b0;
   logic [VEC_W-1:0]  vec_data;
   logic [4:0]        lane_cnt;
`ifdef PSUM_PACK_FLUSH_EN
   logic              flush = 1'b0;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   psum_pack_1_16 #(.DATA_W(DATA_W), .LANES(LANES)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef PSUM_PACK_FLUSH_EN
      .flush     (flush),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready),
      .vec_data  (vec_data),
      .lane_cnt  (lane_cnt)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chkv(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------
   // Reference model: a FIFO of accepted words. Every LANES words form a
   // completed vector; at most two completed vectors can be outstanding.
   // From the word/vector counts alone we predict in_ready, vec_valid and
   // lane_cnt, and each emitted vector must equal the next LANES words.
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] mq[$];
   int                acc_cnt = 0;
   int                out_cnt = 0;
   int                tot_vec = 0;
   bit                prev_hold = 1'b0;
   logic [VEC_W-1:0]  prev_data = '0;

   always @(negedge clk) begin
      int               pending;
      bit               exp_rdy;
      bit               exp_vv;
      logic [VEC_W-1:0] ev;
      if (rst) begin
         mq.delete();
         acc_cnt   = 0;
         out_cnt   = 0;
         prev_hold = 1'b0;
      end else begin
         pending = acc_cnt / LANES - out_cnt;
         exp_rdy = (pending < 2);
         exp_vv  = (pending >= 1);
         chk("mon_in_ready", int'(in_ready), int'(exp_rdy));
         chk("mon_vec_valid", int'(vec_valid), int'(exp_vv));
         chk("mon_lane_cnt", int'(lane_cnt), acc_cnt % LANES);
         if (prev_hold) chkv("mon_hold_stable", vec_data, prev_data);
         prev_hold = vec_valid && !vec_ready;
         prev_data = vec_data;
         if (exp_vv && vec_ready) begin
            ev = '0;
            for (int k = 0; k < LANES; k++) ev[k*DATA_W +: DATA_W] = mq[k];
            chkv("mon_vec_data", vec_data, ev);
            for (int k = 0; k < LANES; k++) void'(mq.pop_front());
            out_cnt++;
            tot_vec++;
         end
         if (in_valid && exp_rdy) begin
            mq.push_back(in_data);
            acc_cnt++;
         end
`ifdef PSUM_PACK_FLUSH_EN
         if (flush && exp_rdy) begin
            while ((acc_cnt % LANES) != 0) begin
               mq.push_back('0);
               acc_cnt++;
            end
         end
`endif
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic              vld;
      logic [DATA_W-1:0] data;
      logic              vrdy;
      logic              exp_ird;
      logic              exp_vv;
      logic [4:0]        exp_lc;
   } vec_t;

   initial begin
      vec_t              tbl[19];
      logic [DATA_W-1:0] fp[16];
      logic [DATA_W-1:0] wa[40];
      logic [DATA_W-1:0] wd[16];
      logic [VEC_W-1:0]  ev;
      int                w;
      int                bubbles;
      int                v0;
      int                sent;
      int                cyc;

      fp = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800,
             16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80, 16'h4C00};
      for (int i = 0; i < 16; i++)
         tbl[i] = '{vld: 1'b1, data: fp[i], vrdy: 1'b1, exp_ird: 1'b1, exp_vv: 1'b0, exp_lc: 5'(i)};
      tbl[16] = '{vld: 1'b0, data: '0, vrdy: 1'b0, exp_ird: 1'b1, exp_vv: 1'b1, exp_lc: 5'd0};
      tbl[17] = '{vld: 1'b0, data: '0, vrdy: 1'b1, exp_ird: 1'b1, exp_vv: 1'b1, exp_lc: 5'd0};
      tbl[18] = '{vld: 1'b0, data: '0, vrdy: 1'b0, exp_ird: 1'b1, exp_vv: 1'b0, exp_lc: 5'd0};

      // Reset state
      tick();
      tick();
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_vec_valid", int'(vec_valid), 0);
      chk("rst_lane_cnt", int'(lane_cnt), 0);
      chkv("rst_vec_data", vec_data, '0);
      rst = 1'b0;

      // Table: 1.0 .. 16.0 streamed, vector inspected, then taken
      ev = '0;
      for (int k = 0; k < LANES; k++) ev[k*DATA_W +: DATA_W] = fp[k];
      for (int i = 0; i < 19; i++) begin
         tick();
         in_valid  = tbl[i].vld;
         in_data   = tbl[i].data;
         vec_ready = tbl[i].vrdy;
         #1;
         chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(tbl[i].exp_ird));
         chk($sformatf("tbl%0d_vec_valid", i), int'(vec_valid), int'(tbl[i].exp_vv));
         chk($sformatf("tbl%0d_lane_cnt", i), int'(lane_cnt), int'(tbl[i].exp_lc));
         if (i == 16) begin
            chk("tbl_lane0", int'(vec_data[15:0]), 'h3C00);
            chk("tbl_lane1", int'(vec_data[31:16]), 'h4000);
            chkv("tbl_vec_data", vec_data, ev);
         end
      end

      // Stall: vec_ready low, 40 words offered, only 32 fit
      for (int i = 0; i < 40; i++) wa[i] = 16'($urandom);
      vec_ready = 1'b0;
      w = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         in_valid = 1'b1;
         in_data  = wa[w];
         #1;
         if (in_ready) w++;
      end
      tick();
      in_valid = 1'b0;
      #1;
      chk("stall_accepted", w, 32);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_vec_valid", int'(vec_valid), 1);
      ev = '0;
      for (int k = 0; k < LANES; k++) ev[k*DATA_W +: DATA_W] = wa[k];
      chkv("stall_vec0", vec_data, ev);
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      #1;
      chk("stall_ready_back", int'(in_ready), 1);
      chk("stall_vec1_valid", int'(vec_valid), 1);
      ev = '0;
      for (int k = 0; k < LANES; k++) ev[k*DATA_W +: DATA_W] = wa[LANES + k];
      chkv("stall_vec1", vec_data, ev);
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      #1;
      chk("stall_drained", int'(vec_valid), 0);

      // Full rate: 64 words back to back, vec_ready always high
      v0 = tot_vec;
      bubbles = 0;
      for (int c = 0; c < 64; c++) begin
         tick();
         in_valid  = 1'b1;
         vec_ready = 1'b1;
         in_data   = 16'($urandom);
         #1;
         if (!in_ready) bubbles++;
      end
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("rate_bubbles", bubbles, 0);
      chk("rate_vectors", tot_vec - v0, 4);

      // Random gaps on both sides, 1000 words
      v0 = tot_vec;
      sent = 0;
      cyc = 0;
      while (sent < 1000 && cyc < 20000) begin
         tick();
         cyc++;
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 16'($urandom);
         vec_ready = ($urandom_range(0, 9) < 3);
         #1;
         if (in_valid && in_ready) sent++;
      end
      tick();
      in_valid  = 1'b0;
      vec_ready = 1'b1;
      repeat (40) tick();
      vec_ready = 1'b0;
      chk("rand_in_budget", sent, 1000);
      chk("rand_vectors", tot_vec - v0, 62);
      chk("rand_partial", int'(lane_cnt), 8);

      // Reset while a vector is pending and a second bank is partly filled
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 23; i++) begin
         tick();
         in_valid = 1'b1;
         in_data  = 16'($urandom);
      end
      tick();
      in_valid = 1'b0;
      #1;
      chk("prerst_vec_valid", int'(vec_valid), 1);
      chk("prerst_lane_cnt", int'(lane_cnt), 7);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_vec_valid", int'(vec_valid), 0);
      chk("arst_lane_cnt", int'(lane_cnt), 0);
      chkv("arst_vec_data", vec_data, '0);
      chk("arst_in_ready", int'(in_ready), 1);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) wd[i] = 16'($urandom);
      for (int i = 0; i < 16; i++) begin
         tick();
         in_valid = 1'b1;
         in_data  = wd[i];
      end
      tick();
      in_valid = 1'b0;
      #1;
      ev = '0;
      for (int k = 0; k < LANES; k++) ev[k*DATA_W +: DATA_W] = wd[k];
      chk("postrst_vec_valid", int'(vec_valid), 1);
      chkv("postrst_vec_data", vec_data, ev);
      chk("postrst_lane_cnt", int'(lane_cnt), 0);
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      #1;
      chk("postrst_taken", int'(vec_valid), 0);

`ifdef PSUM_PACK_FLUSH_EN
      // Flush after 5 words pads the rest with +0.0
      for (int i = 0; i < 5; i++) begin
         tick();
         in_valid = 1'b1;
         in_data  = 16'h3C00;
      end
      tick();
      in_valid = 1'b0;
      flush    = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      ev = '0;
      for (int k = 0; k < 5; k++) ev[k*DATA_W +: DATA_W] = 16'h3C00;
      chk("flush_vec_valid", int'(vec_valid), 1);
      chk("flush_lane_cnt", int'(lane_cnt), 0);
      chkv("flush_vec_data", vec_data, ev);
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      flush     = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("flush_empty_no_vec", int'(vec_valid), 0);
      chk("flush_empty_lane_cnt", int'(lane_cnt), 0);
      // Word and flush on the same beat: word lands, then padding
      for (int i = 0; i < 4; i++) begin
         tick();
         in_valid = 1'b1;
         in_data  = wd[i];
         flush    = (i == 3);
      end
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      #1;
      ev = '0;
      for (int k = 0; k < 4; k++) ev[k*DATA_W +: DATA_W] = wd[k];
      chk("flushw_vec_valid", int'(vec_valid), 1);
      chkv("flushw_vec_data", vec_data, ev);
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
